// File: rtl/fp_mul_iter_if.sv
// fp_mul_iter_if: operand/result bundle for the iterative binary32 multiplier.
//   a, b    : operands (binary32)
//   start   : request, honoured when enable=1 and busy=0
//   enable  : global advance; 0 stalls the unit
//   p       : registered product
//   busy    : operation in flight
//   done    : one-cycle completion pulse
// master = controller side, slave = multiplier side.
interface fp_mul_iter_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        enable;
    logic [31:0] p;
    logic        busy;
    logic        done;

    modport master (
        output a, b, start, enable,
        input  p, busy, done
    );

    modport slave (
        input  a, b, start, enable,
        output p, busy, done
    );
endinterface

// File: rtl/fp_mul_iter.sv
// fp_mul_iter: iterative IEEE-754 single-precision multiplier.
// Shift-add mantissa product, then one normalise/round (RNE) cycle.
// Shares the start/enable/busy/done handshake of the iterative divider.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fp_mul_iter_if.slave (a, b, start, enable in; p, busy, done out)
// Optional feature: define FMUL_RADIX4_EN to retire two multiplier bits per
// cycle (13-edge latency instead of 25); results are bit-identical.
module fp_mul_iter #(
    parameter int unsigned MANT_W   = 24,
    parameter int unsigned EXP_BIAS = 127
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_iter_if.slave bus
);

    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned FRAC_W = MANT_W - 1;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned EXP_W  = 10;
`ifdef FMUL_RADIX4_EN
    localparam int unsigned ITERS  = MANT_W / 2;
`else
    localparam int unsigned ITERS  = MANT_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [MANT_W-1:0]        r_ma;
    logic [MANT_W-1:0]        r_mb;
`ifdef FMUL_RADIX4_EN
    logic [MANT_W+1:0]        r_ma3;
`endif
    logic [PROD_W-1:0]        r_acc;
    logic                     r_sign;
    logic signed [EXP_W-1:0]  r_exp_sum;
    logic                     r_spec;
    logic [31:0]              r_spec_val;
    logic [31:0]              r_p;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_load;
    logic                     w_step;
    logic                     w_finish;

    assign bus.p    = r_p;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

    // Operand unpack and special-case classification at the sampling edge
    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic [FRAC_W-1:0] w_fa;
    logic [FRAC_W-1:0] w_fb;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic              w_sign_in;
    logic              w_spec_in;
    logic [31:0]       w_spec_val_in;

    assign w_ea      = bus.a[30:23];
    assign w_eb      = bus.b[30:23];
    assign w_fa      = bus.a[FRAC_W-1:0];
    assign w_fb      = bus.b[FRAC_W-1:0];
    assign w_a_nan   = (w_ea == 8'hff) && (w_fa != '0);
    assign w_b_nan   = (w_eb == 8'hff) && (w_fb != '0);
    assign w_a_inf   = (w_ea == 8'hff) && (w_fa == '0);
    assign w_b_inf   = (w_eb == 8'hff) && (w_fb == '0);
    // Denormals are flushed, so a zero exponent means zero
    assign w_a_zero  = (w_ea == 8'h00);
    assign w_b_zero  = (w_eb == 8'h00);
    assign w_sign_in = bus.a[31] ^ bus.b[31];

    always_comb begin
        w_spec_in     = 1'b1;
        w_spec_val_in = 32'h0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_val_in = 32'h7fc0_0000;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_val_in = {w_sign_in, 8'hff, 23'h0};
        end else if (w_a_zero || w_b_zero) begin
            w_spec_val_in = {w_sign_in, 31'h0};
        end else begin
            w_spec_in = 1'b0;
        end
    end

    // Partial product for the current iteration
    logic [PROD_W-1:0] w_pp;
`ifdef FMUL_RADIX4_EN
    logic [1:0] w_digit;
    assign w_digit = 2'(r_mb >> {r_cnt, 1'b0});
    always_comb begin
        w_pp = '0;
        case (w_digit)
            2'd1:    w_pp = PROD_W'(r_ma);
            2'd2:    w_pp = PROD_W'({r_ma, 1'b0});
            2'd3:    w_pp = PROD_W'(r_ma3);
            default: w_pp = '0;
        endcase
        w_pp = w_pp << {r_cnt, 1'b0};
    end
`else
    assign w_pp = r_mb[r_cnt] ? (PROD_W'(r_ma) << r_cnt) : '0;
`endif

    // Normalise and round-to-nearest-even from the finished accumulator
    logic                    w_hi;
    logic [FRAC_W-1:0]       w_frac;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_rnd;
    logic [MANT_W-1:0]       w_frac_r;
    logic                    w_carry;
    logic signed [EXP_W-1:0] w_exp_fin;
    logic [31:0]             w_p_norm;

    assign w_hi     = r_acc[PROD_W-1];
    assign w_frac   = w_hi ? r_acc[PROD_W-2 -: FRAC_W] : r_acc[PROD_W-3 -: FRAC_W];
    assign w_guard  = w_hi ? r_acc[MANT_W-1] : r_acc[MANT_W-2];
    assign w_sticky = w_hi ? (|r_acc[MANT_W-2:0]) : (|r_acc[MANT_W-3:0]);
    assign w_rnd    = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_r = {1'b0, w_frac} + MANT_W'(w_rnd);
    // Carry out of the fraction means the significand rounded up to 2.0
    assign w_carry  = w_frac_r[FRAC_W];
    assign w_exp_fin = r_exp_sum + EXP_W'(w_hi) + EXP_W'(w_carry);

    always_comb begin
        w_p_norm = {r_sign, w_exp_fin[7:0], w_frac_r[FRAC_W-1:0]};
        if (r_spec) begin
            w_p_norm = r_spec_val;
        end else if (w_exp_fin >= 10'sd255) begin
            w_p_norm = {r_sign, 8'hff, 23'h0};
        end else if (w_exp_fin <= 10'sd0) begin
            w_p_norm = {r_sign, 31'h0};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; enable=0 holds the current state
    always_comb begin
        w_state_nxt = r_state;
        if (bus.enable) begin
            case (r_state)
                S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
                S_CALC:  if (r_cnt == LAST_CNT) w_state_nxt = S_NORM;
                S_NORM:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-state strobes driving the datapath registers
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        if (bus.enable) begin
            case (r_state)
                S_IDLE:  w_load   = bus.start;
                S_CALC:  w_step   = 1'b1;
                S_NORM:  w_finish = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
`ifdef FMUL_RADIX4_EN
            r_ma3      <= '0;
`endif
            r_acc      <= '0;
            r_sign     <= 1'b0;
            r_exp_sum  <= '0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_p        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_ma       <= {~w_a_zero, w_fa};
                r_mb       <= {~w_b_zero, w_fb};
`ifdef FMUL_RADIX4_EN
                r_ma3      <= (MANT_W+2)'({~w_a_zero, w_fa}) + (MANT_W+2)'({~w_a_zero, w_fa, 1'b0});
`endif
                r_acc      <= '0;
                r_cnt      <= '0;
                r_sign     <= w_sign_in;
                r_exp_sum  <= EXP_W'(w_ea) + EXP_W'(w_eb) - EXP_W'(EXP_BIAS);
                r_spec     <= w_spec_in;
                r_spec_val <= w_spec_val_in;
                r_busy     <= 1'b1;
            end
            if (w_step) begin
                r_acc <= r_acc + w_pp;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_p    <= w_p_norm;
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_iter.sv
// tb_fp_mul_iter: scoreboard bench for fp_mul_iter (radix-2 or FMUL_RADIX4_EN).
module tb_fp_mul_iter;

`ifdef FMUL_RADIX4_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 25;
`endif
    localparam int MAX_WAIT = 200;

    logic clk = 1'b0;
    logic rst;
    fp_mul_iter_if bus ();

    fp_mul_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];

    // Drive a request and push its expected product; returns #1 after the sampling edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input bit hold);
        bus.a      = a;
        bus.b      = b;
        bus.start  = 1'b1;
        bus.enable = 1'b1;
        sb_q.push_back(exp_p);
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Count edges until done; optionally stall enable for stall_len edges after edge stall_at
    task automatic wait_done(input int stall_at, input int stall_len,
                             output int lat, output int busy_cyc, output int stall_dones,
                             output bit timeout, output logic [31:0] p_obs);
        bit got;
        got         = 1'b0;
        lat         = 0;
        stall_dones = 0;
        p_obs       = 32'hx;
        busy_cyc    = bus.busy ? 1 : 0;
        for (int k = 1; k <= MAX_WAIT && !got; k++) begin
            @(posedge clk); #1;
            if (stall_len > 0 && k > stall_at && k <= stall_at + stall_len && bus.done)
                stall_dones++;
            if (stall_len > 0 && k == stall_at) bus.enable = 1'b0;
            if (stall_len > 0 && k == stall_at + stall_len) bus.enable = 1'b1;
            if (bus.done && !(stall_len > 0 && k > stall_at && k <= stall_at + stall_len)) begin
                got   = 1'b1;
                lat   = k;
                p_obs = bus.p;
            end else if (bus.busy) begin
                busy_cyc++;
            end
        end
        timeout = !got;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.a      = '0;
        bus.b      = '0;
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.p !== 32'h0) begin
            failures++; $display("FAIL reset_p got=%h want=00000000", bus.p);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b want=0", bus.done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, busy_cyc, sd;
        bit to;
        logic [31:0] p_obs, exp_p, p_hold;
        issue(32'h4306_1000, 32'hc010_0000, 32'hc396_d200, 1'b0);
        wait_done(0, 0, lat, busy_cyc, sd, to, p_obs);
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
        checks++;
        if (to || lat != LAT) begin
            failures++; $display("FAIL basic_latency got=%0d want=%0d timeout=%0b", lat, LAT, to);
        end
        checks++;
        if (busy_cyc != LAT) begin
            failures++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cyc, LAT);
        end
        checks++;
        if (p_obs !== exp_p) begin
            failures++; $display("FAIL basic_p got=%h want=%h", p_obs, exp_p);
        end
        p_hold = exp_p;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.p !== p_hold || bus.done !== 1'b0) begin
            failures++; $display("FAIL basic_hold got p=%h done=%b want p=%h done=0", bus.p, bus.done, p_hold);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy_cyc, sd;
        bit to;
        logic [31:0] p_obs, exp_p;
        // start stays high through busy with junk operands; it must be ignored
        issue(32'h40f0_0000, 32'h4178_0000, 32'h42e8_8000, 1'b1);
        bus.a = 32'hdead_beef;
        bus.b = 32'h3f80_0000;
        wait_done(0, 0, lat, busy_cyc, sd, to, p_obs);
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
        checks++;
        if (to || lat != LAT || p_obs !== exp_p) begin
            failures++; $display("FAIL b2b_first got p=%h lat=%0d want p=%h lat=%0d", p_obs, lat, exp_p, LAT);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL b2b_idle_busy got=%b want=0", bus.busy);
        end
        issue(32'hc168_0000, 32'hbec0_0000, 32'h40ae_0000, 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL b2b_second_accept got busy=%b want=1", bus.busy);
        end
        wait_done(0, 0, lat, busy_cyc, sd, to, p_obs);
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
        checks++;
        if (to || lat != LAT || p_obs !== exp_p) begin
            failures++; $display("FAIL b2b_second got p=%h lat=%0d want p=%h lat=%0d", p_obs, lat, exp_p, LAT);
        end
    endtask

    task automatic test_arith_specials();
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        logic [31:0] te[6];
        int lat, busy_cyc, sd;
        bit to;
        logic [31:0] p_obs, exp_p;
        ta[0] = 32'h3f80_0001; tb[0] = 32'h3f80_0001; te[0] = 32'h3f80_0002; // RNE
        ta[1] = 32'h7f00_0000; tb[1] = 32'h4000_0000; te[1] = 32'h7f80_0000; // overflow
        ta[2] = 32'h7f80_0000; tb[2] = 32'h0000_0000; te[2] = 32'h7fc0_0000; // inf*0
        ta[3] = 32'h8000_0000; tb[3] = 32'h4040_0000; te[3] = 32'h8000_0000; // -0*3
        ta[4] = 32'h0000_0001; tb[4] = 32'h3f80_0000; te[4] = 32'h0000_0000; // denormal
        ta[5] = 32'hff80_0000; tb[5] = 32'h4000_0000; te[5] = 32'hff80_0000; // -inf*2
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], te[i], 1'b0);
            wait_done(0, 0, lat, busy_cyc, sd, to, p_obs);
            exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
            checks++;
            if (to || lat != LAT || p_obs !== exp_p) begin
                failures++;
                $display("FAIL arith_case%0d a=%h b=%h got p=%h lat=%0d want p=%h lat=%0d",
                         i, ta[i], tb[i], p_obs, lat, exp_p, LAT);
            end
        end
    endtask

    task automatic test_stall();
        int lat, busy_cyc, sd;
        bit to;
        logic [31:0] p_obs, exp_p;
        issue(32'h4306_1000, 32'hc010_0000, 32'hc396_d200, 1'b0);
        wait_done(5, 5, lat, busy_cyc, sd, to, p_obs);
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
        checks++;
        if (to || lat != LAT + 5) begin
            failures++; $display("FAIL stall_latency got=%0d want=%0d timeout=%0b", lat, LAT + 5, to);
        end
        checks++;
        if (p_obs !== exp_p) begin
            failures++; $display("FAIL stall_p got=%h want=%h", p_obs, exp_p);
        end
        checks++;
        if (sd != 0) begin
            failures++; $display("FAIL stall_done_pulses got=%0d want=0", sd);
        end
    endtask

    task automatic test_midop_reset();
        int lat, busy_cyc, sd, dones;
        bit to;
        logic [31:0] p_obs, exp_p;
        issue(32'h4306_1000, 32'hc010_0000, 32'hc396_d200, 1'b0);
        // aborted operation never produces a result
        void'(sb_q.pop_front());
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.p !== 32'h0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state got busy=%b p=%h done=%b want busy=0 p=00000000 done=0",
                     bus.busy, bus.p, bus.done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++; $display("FAIL midreset_quiet got activity=%0d want=0", dones);
        end
        issue(32'h40f0_0000, 32'h4178_0000, 32'h42e8_8000, 1'b0);
        wait_done(0, 0, lat, busy_cyc, sd, to, p_obs);
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
        checks++;
        if (to || lat != LAT || p_obs !== exp_p) begin
            failures++; $display("FAIL midreset_fresh got p=%h lat=%0d want p=%h lat=%0d", p_obs, lat, exp_p, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_arith_specials();
        test_stall();
        test_midop_reset();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_iter.md
Name: fp_mul_iter

Overview:
- Iterative IEEE-754 single-precision multiplier; the inverse operation of the team's iterative FP divider.
- Uses the same start/enable/busy handshake as the divider, so a controller can drive either unit the same way.
- Used for quotient check-back (q*e == d) and as the FMUL execution unit in the arch datapath.
- Mantissa product is built by shift-add, one multiplier bit per cycle, then normalised and rounded in a final cycle.

Parameters:
- MANT_W, 24, significand width including hidden bit (fixed for binary32; changing it is unsupported).
- EXP_BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- a  input  32  multiplicand, binary32.
- b  input  32  multiplier, binary32.
- start  input  1  request; sampled only when enable=1 and busy=0.
- enable  input  1  global advance; when 0, all state holds (stall).
- p  output  32  product, registered.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when p is updated.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; p=32'h0; busy=0; done=0; internal accumulators cleared.
- Reset mid-operation: the operation is aborted and no done pulse is produced.
- FSM states and transitions:
  - IDLE: on edge with enable&start, latch a/b, unpack, classify, set busy=1, go to CALC with counter=0.
  - CALC: each enabled edge, if mb[cnt]=1, add ma<<cnt into the 48-bit accumulator; cnt++. After 24 iterations, go to NORM.
  - NORM: one enabled edge; compute sign, exponent and rounding. Write p, done=1, busy=0, go to IDLE.
- Latency: 25 enabled edges from the sampling edge to the edge that writes p. Latency is fixed; special operands use the same latency.
- enable=0 freezes the FSM, counter, accumulator, p and busy; done is forced 0 during the stall.
- start while busy=1 is ignored. A new start may be sampled on the same edge that done is asserted only if busy was 0 before that edge; otherwise earliest is the next edge.
- done is high for exactly one cycle. p holds its value until the next completion.
- Arithmetic:
  - sign = sa^sb.
  - exp = ea+eb-127, +1 if product bit 47 is set.
  - Mantissa uses round-to-nearest-even with guard and sticky taken from the low product bits.
  - A rounding carry renormalises and increments the exponent.
- Special cases, checked in order:
  - Any NaN operand, or inf*0: p=32'h7fc00000.
  - inf*finite nonzero: p = signed inf.
  - zero operand, or denormal operand (flushed to zero, as in the divider): p = signed zero.
  - exp>=255 after rounding: signed inf (0x7f800000 / 0xff800000).
  - exp<=0: signed zero (no denormal output).

Optional Feature:
- Macro FMUL_RADIX4_EN.
- When defined, CALC consumes 2 multiplier bits per cycle: it adds 0, ma, 2ma or 3ma shifted by 2*cnt, with 3ma precomputed at latch. CALC takes 12 cycles and total latency is 13 enabled edges.
- When undefined, the unit is radix-2 with a 25-edge latency.
- Result bits are identical in both modes.

Test Plan:
- Basic product: a=0x43061000, b=0xc0100000, start pulse with enable=1 -> done after 25 edges, p=0xc396d200; busy high for exactly those 25 cycles.
- Back-to-back: a=0x40f00000, b=0x41780000, then a=0xc1680000, b=0xbec00000 issued on the first edge with busy=0 -> p=0x42e88000 then p=0x40ae0000. A start held high during busy is ignored.
- Rounding: a=0x3f800001, b=0x3f800001 -> p=0x3f800002. Overflow: a=0x7f000000, b=0x40000000 -> p=0x7f800000.
- Specials: 0x7f800000*0x00000000 -> 0x7fc00000; 0x80000000*0x40400000 -> 0x80000000; denormal 0x00000001*0x3f800000 -> 0x00000000.
- Stall: drop enable for 5 cycles mid-CALC with a=0x43061000, b=0xc0100000 -> done arrives 30 cycles after start, same p; no done during the stall.
- Reset: assert rst at CALC cycle 10 -> busy=0, p=0, no done. A fresh op afterwards completes normally. With FMUL_RADIX4_EN defined, rerun all cases expecting a 13-edge latency.
